// File: rtl/alu_client_pkg.sv
// Shared opcode and FSM encodings for the ALU client and its bench.
// Also provides the helper that says whether an opcode's carry flag is meaningful.
package alu_client_pkg;

    localparam int unsigned CmdW    = 3;
    localparam int unsigned DataW   = 4;
    localparam int unsigned CountW  = 8;
    localparam int unsigned LatCntW = 3;

    typedef enum logic [CmdW-1:0] {
        CmdAdd = 3'b000,
        CmdSub = 3'b001,
        CmdNot = 3'b010,
        CmdAnd = 3'b011,
        CmdOr  = 3'b100,
        CmdXor = 3'b101,
        CmdLt  = 3'b110,
        CmdEq  = 3'b111
    } alu_cmd_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StResp  = 2'd2
    } state_e;

    // Only add and sub produce a carry worth comparing.
    function automatic logic cmd_has_carry(logic [CmdW-1:0] cmd);
        return (cmd == CmdAdd) || (cmd == CmdSub);
    endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference ALU used to judge the external ALU's answers.
module alu_golden
    import alu_client_pkg::*;
(
    input  logic [CmdW-1:0]  cmd_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    output logic [DataW-1:0] s_o,
    output logic             c_o
);

    always_comb begin
        s_o = '0;
        c_o = 1'b0;
        unique case (alu_cmd_e'(cmd_i))
            CmdAdd: {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i};
            // Subtract as add of the two's complement; b=0 gives no carry.
            CmdSub: {c_o, s_o} = {1'b0, a_i} + {1'b0, 4'(~b_i + 4'd1)};
            CmdNot: s_o = ~a_i;
            CmdAnd: s_o = a_i & b_i;
            CmdOr:  s_o = a_i | b_i;
            CmdXor: s_o = a_i ^ b_i;
            CmdLt:  s_o = {3'b000, ($signed(a_i) < $signed(b_i))};
            CmdEq:  s_o = {3'b000, (a_i == b_i)};
            default: begin
                s_o = '0;
                c_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_client.sv
// Issues one request at a time to an external ALU, waits ALU_LAT+1 cycles,
// captures its answer against a golden model and counts operations and errors.
module alu_client
    import alu_client_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CmdW-1:0]   req_cmd,
    input  logic [DataW-1:0]  req_a,
    input  logic [DataW-1:0]  req_b,
    output logic [CmdW-1:0]   alu_cmd,
    output logic [DataW-1:0]  alu_a,
    output logic [DataW-1:0]  alu_b,
    input  logic [DataW-1:0]  alu_ans,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DataW-1:0]  rsp_ans,
    output logic              rsp_ovf,
    output logic              rsp_mismatch,
    output logic [CountW-1:0] op_count,
    output logic [CountW-1:0] err_count
);

    localparam logic [LatCntW-1:0] LastCnt = LatCntW'(ALU_LAT);

    state_e              state_q, state_d;
    logic [LatCntW-1:0]  cnt_q, cnt_d;
    logic [CmdW-1:0]     cmd_q, cmd_d;
    logic [DataW-1:0]    a_q, a_d, b_q, b_d;
    logic [DataW-1:0]    ans_q, ans_d;
    logic                ovf_q, ovf_d, mis_q, mis_d;
    logic [CountW-1:0]   op_q, op_d, err_q, err_d;

    logic [DataW-1:0]    gold_s;
    logic                gold_c;
    logic                mismatch;

    alu_golden u_golden (
        .cmd_i (cmd_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .s_o   (gold_s),
        .c_o   (gold_c)
    );

    assign mismatch = (alu_ans != gold_s) || (cmd_has_carry(cmd_q) && (alu_ovf != gold_c));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        a_d     = a_q;
        b_d     = b_q;
        ans_d   = ans_q;
        ovf_d   = ovf_q;
        mis_d   = mis_q;
        op_d    = op_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    a_d     = req_a;
                    b_d     = req_b;
                    cnt_d   = '0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == LastCnt) begin
                    ans_d   = alu_ans;
                    ovf_d   = alu_ovf;
                    mis_d   = mismatch;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    op_d = op_q + 8'd1;
                    if (mis_q && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ans_q   <= '0;
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
            op_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ans_q   <= ans_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign alu_cmd      = cmd_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_ans      = ans_q;
    assign rsp_ovf      = ovf_q;
    assign rsp_mismatch = mis_q;
    assign op_count     = op_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_alu_client.sv
// Bench for alu_client: emulates a latency-ALU_LAT ALU and checks every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_alu_client;
    import alu_client_pkg::*;

    localparam int unsigned LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0] req_cmd, alu_cmd;
    logic [3:0] req_a, req_b, alu_a, alu_b, alu_ans, rsp_ans;
    logic       alu_ovf, rsp_ovf, rsp_mismatch;
    logic [7:0] op_count, err_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    alu_client #(.ALU_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_cmd      (alu_cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ans      (alu_ans),
        .alu_ovf      (alu_ovf),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_ans      (rsp_ans),
        .rsp_ovf      (rsp_ovf),
        .rsp_mismatch (rsp_mismatch),
        .op_count     (op_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference arithmetic in plain integers: returns {carry, sum}.
    function automatic logic [4:0] ref_alu(logic [2:0] cmd, logic [3:0] a, logic [3:0] b);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        case (cmd)
            3'd0:    r = ia + ib;
            3'd1:    r = ia + ((16 - ib) % 16);
            3'd2:    r = 15 - ia;
            3'd3:    r = int'(a & b);
            3'd4:    r = int'(a | b);
            3'd5:    r = int'(a ^ b);
            3'd6:    r = (sa < sb) ? 1 : 0;
            default: r = (ia == ib) ? 1 : 0;
        endcase
        return 5'(r);
    endfunction

    // Emulated ALU: garbage until operands have been stable LAT cycles.
    // Flags are garbage (1) for non-arithmetic ops to exercise the ignore rule.
    int unsigned stab = 0;
    logic [10:0] snap = '0;
    bit          force_bad = 1'b0;
    logic [4:0]  good;
    logic        good_ovf;

    always @(posedge clk) begin
        #1;
        if ({alu_cmd, alu_a, alu_b} != snap) begin
            snap = {alu_cmd, alu_a, alu_b};
            stab = 0;
        end else if (stab < 15) begin
            stab++;
        end
    end

    assign good     = ref_alu(alu_cmd, alu_a, alu_b);
    assign good_ovf = (alu_cmd <= 3'd1) ? good[4] : 1'b1;
    assign alu_ans  = (stab >= LAT) ? (force_bad ? (good[3:0] ^ 4'h1) : good[3:0]) : ~good[3:0];
    assign alu_ovf  = (stab >= LAT) ? good_ovf : ~good_ovf;

    // Transaction model: age counts cycles since acceptance.
    bit          m_busy;
    int unsigned m_age, m_op, m_err;
    logic [2:0]  m_cmd;
    logic [3:0]  m_a, m_b, m_ans;
    logic        m_ovf, m_mis;
    logic [4:0]  m_r;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_age = 0; m_op = 0; m_err = 0;
            m_cmd = '0; m_a = '0; m_b = '0; m_ans = '0; m_ovf = 0; m_mis = 0;
        end
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && (m_age == LAT + 2)));
        chk("alu_ops", 32'({alu_cmd, alu_a, alu_b}), 32'({m_cmd, m_a, m_b}));
        chk("rsp_ans", 32'(rsp_ans), 32'(m_ans));
        chk("rsp_flags", 32'({rsp_ovf, rsp_mismatch}), 32'({m_ovf, m_mis}));
        chk("op_count", 32'(op_count), m_op);
        chk("err_count", 32'(err_count), m_err);
        if (!rst) begin
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_age = 1;
                    m_cmd = req_cmd; m_a = req_a; m_b = req_b;
                end
            end else if (m_age == LAT + 1) begin
                m_r   = ref_alu(m_cmd, m_a, m_b);
                m_ans = force_bad ? (m_r[3:0] ^ 4'h1) : m_r[3:0];
                m_ovf = (m_cmd <= 3'd1) ? m_r[4] : 1'b1;
                m_mis = force_bad;
                m_age++;
            end else if (m_age == LAT + 2) begin
                if (rsp_ready) begin
                    m_busy = 0;
                    m_op   = (m_op + 1) % 256;
                    if (m_mis && m_err < 255) m_err++;
                end
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b,
                          input bit bad, input int stall, output int lat,
                          output logic [3:0] ans, output logic ovf, output logic mis);
        int n;
        force_bad = bad;
        req_cmd = c; req_a = a; req_b = b; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("accept_wait", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin tick(); lat++; end
        chk("rsp_wait", 32'(rsp_valid), 1);
        ans = rsp_ans; ovf = rsp_ovf; mis = rsp_mismatch;
        repeat (stall) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         lat, n;
        logic [3:0] ans;
        logic       ovf, mis;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_cmd = '0; req_a = '0; req_b = '0;
        repeat (3) tick();
        chk("reset_ready", 32'(req_ready), 1);
        chk("reset_valid", 32'(rsp_valid), 0);
        chk("reset_op", 32'(op_count), 0);
        rst = 1'b0;
        tick();

        run_op(3'b000, 4'd7, 4'd9, 0, 0, lat, ans, ovf, mis);
        chk("add_ans", 32'(ans), 0);
        chk("add_ovf", 32'(ovf), 1);
        chk("add_mis", 32'(mis), 0);
        chk("add_opcnt", 32'(op_count), 1);

        run_op(3'b001, 4'd5, 4'd3, 0, 1, lat, ans, ovf, mis);
        chk("sub53", 32'({ans, ovf, mis}), 32'({4'd2, 1'b1, 1'b0}));
        run_op(3'b001, 4'd5, 4'd0, 0, 0, lat, ans, ovf, mis);
        chk("sub50", 32'({ans, ovf, mis}), 32'({4'd5, 1'b0, 1'b0}));
        run_op(3'b010, 4'b0101, 4'd0, 0, 0, lat, ans, ovf, mis);
        chk("not5", 32'({ans, mis}), 32'({4'd10, 1'b0}));
        run_op(3'b101, 4'd12, 4'd10, 0, 0, lat, ans, ovf, mis);
        chk("xor_ovf_ignored", 32'({ans, ovf, mis}), 32'({4'd6, 1'b1, 1'b0}));

        run_op(3'b110, 4'b1000, 4'd0, 1, 0, lat, ans, ovf, mis);
        chk("slt_forced", 32'({ans, mis}), 32'({4'd0, 1'b1}));
        chk("slt_errcnt", 32'(err_count), 1);
        run_op(3'b110, 4'd3, 4'b1111, 0, 0, lat, ans, ovf, mis);
        chk("slt_3_m1", 32'({ans, mis}), 32'({4'd0, 1'b0}));
        run_op(3'b111, 4'd9, 4'd9, 0, 0, lat, ans, ovf, mis);
        chk("eq99", 32'(ans), 1);

        // Latency and backpressure.
        run_op(3'b011, 4'd14, 4'd7, 0, 10, lat, ans, ovf, mis);
        chk("latency", 32'(lat), LAT + 2);
        chk("and_ans", 32'(ans), 6);

        // rsp_ready high while idle and driving must be ignored.
        rsp_ready = 1'b1;
        repeat (3) tick();
        run_op(3'b100, 4'd8, 4'd1, 0, 0, lat, ans, ovf, mis);
        chk("or_ans", 32'(ans), 9);
        chk("early_ready_op", 32'(op_count), 10);

        // Reset during DRIVE.
        req_cmd = 3'b000; req_a = 4'd3; req_b = 4'd4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_drive_busy", 32'(req_ready), 0);
        rst = 1'b1;
        #1;
        chk("rst_async_ops", 32'({alu_cmd, alu_a, alu_b}), 0);
        chk("rst_async_rsp", 32'({rsp_ans, rsp_ovf, rsp_mismatch}), 0);
        chk("rst_async_cnt", 32'({op_count, err_count}), 0);
        chk("rst_async_ready", 32'(req_ready), 1);
        tick(); tick();
        req_cmd = 3'b101; req_a = 4'd6; req_b = 4'd3; req_valid = 1'b1;
        rst = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("post_rst_accept", 32'({req_ready, alu_a}), 32'({1'b0, 4'd6}));
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rst_opcnt", 32'(op_count), 1);

        // Counter wrap and saturation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            run_op(3'(i % 8), 4'(i % 16), 4'((i * 7) % 16), 0, 0, lat, ans, ovf, mis);
        end
        chk("op_wrap", 32'(op_count), 0);
        chk("err_none", 32'(err_count), 0);
        for (int i = 0; i < 260; i++) begin
            run_op(3'(i % 8), 4'((i * 3) % 16), 4'(i % 16), 1, 0, lat, ans, ovf, mis);
        end
        chk("err_sat", 32'(err_count), 255);
        chk("op_after", 32'(op_count), 4);
        force_bad = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
